data_bus_arbiter_ctrl: RTL

//  Next-generation data-bus controller between the core load/store unit and memory-mapped slaves.

---
 rtl/data_bus_arbiter_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/data_bus_arbiter_ctrl.sv
// Data-bus controller: decodes LSU accesses to RAM, GPIO or unmapped space.
// Optional macro DBC_MISALIGN_CHECK_EN rejects misaligned half/word accesses.
module data_bus_arbiter_ctrl #(
   parameter int          RAM_ADDR_WIDTH = 12,
   parameter int          RAM_WAIT       = 0,
   parameter int          GPIO_WIDTH     = 16,
   parameter logic [31:0] GPIO_BASE      = 32'h1000_0000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rd,
   input  logic                      wd,
   input  logic [1:0]                size,
   input  logic [31:0]               addr,
   input  logic [31:0]               data_in,
   output logic [31:0]               data_out,
   output logic                      busy,
   output logic                      done,
   output logic                      err,
   output logic                      ram_en,
   output logic [3:0]                ram_we,
   output logic [RAM_ADDR_WIDTH-3:0] ram_addr,
   output logic [31:0]               ram_wdata,
   input  logic [31:0]               ram_rdata,
   inout  wire  [GPIO_WIDTH-1:0]     gpio
);

   typedef enum logic [2:0] {
      S_IDLE, S_ACCESS, S_WAIT, S_CAPTURE, S_DONE
   } state_t;

   state_t state_q, state_d;
   logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0] wdat_q, wdat_d, dout_q, dout_d;
   logic [1:0] size_q, size_d;
   logic we_q, we_d, err_q, err_d, gsel_q, gsel_d;
   logic [3:0] wait_q, wait_d;
   logic [GPIO_WIDTH-1:0] out_q, out_d, dir_q, dir_d;
   logic [GPIO_WIDTH-1:0] sync1_q, sync2_q;

   logic req, hit_ram, hit_gpio, mis, bad;
   logic [1:0] off;
   logic [3:0] lanes;
   logic [31:0] bmask, smask, wrep, reg_v, gpio_rd, ram_rd;

   assign req      = rd | wd;
   assign hit_ram  = (addr >> RAM_ADDR_WIDTH) == '0;
   assign hit_gpio = addr[31:4] == GPIO_BASE[31:4];

`ifdef DBC_MISALIGN_CHECK_EN
   assign mis = (size == 2'b01 && addr[0]) ||
                (size == 2'b10 && addr[1:0] != 2'b00);
`else
   assign mis = 1'b0;
`endif

   assign bad = (rd & wd) | (size == 2'b11) | mis |
                ~(hit_ram | hit_gpio);

   // Low address bits beyond the access size are ignored.
   always_comb begin
      off   = 2'b00;
      lanes = 4'b1111;
      smask = 32'hFFFF_FFFF;
      wrep  = wdat_q;
      unique case (size_q)
         2'b00: begin
            off   = addr_q[1:0];
            lanes = 4'b0001 << addr_q[1:0];
            smask = 32'h0000_00FF;
            wrep  = {4{wdat_q[7:0]}};
         end
         2'b01: begin
            off   = {addr_q[1], 1'b0};
            lanes = addr_q[1] ? 4'b1100 : 4'b0011;
            smask = 32'h0000_FFFF;
            wrep  = {2{wdat_q[15:0]}};
         end
         default: ;
      endcase
      bmask = {{8{lanes[3]}}, {8{lanes[2]}},
               {8{lanes[1]}}, {8{lanes[0]}}};
   end

   always_comb begin
      reg_v = '0;
      unique case (addr_q[3:2])
         2'd0:    reg_v = 32'(out_q);
         2'd1:    reg_v = 32'(dir_q);
         2'd2:    reg_v = 32'(sync2_q);
         default: reg_v = '0;
      endcase
      gpio_rd = (reg_v >> {off, 3'b000}) & smask;
      ram_rd  = (ram_rdata >> {off, 3'b000}) & smask;
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdat_d  = wdat_q;
      dout_d  = dout_q;
      size_d  = size_q;
      we_d    = we_q;
      err_d   = err_q;
      gsel_d  = gsel_q;
      wait_d  = wait_q;
      out_d   = out_q;
      dir_d   = dir_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (req) begin
               addr_d  = addr[RAM_ADDR_WIDTH-1:0];
               size_d  = size;
               wdat_d  = data_in;
               we_d    = wd;
               err_d   = bad;
               gsel_d  = hit_gpio;
               state_d = bad ? S_DONE : S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (gsel_q) begin
               state_d = S_DONE;
               if (we_q) begin
                  unique case (addr_q[3:2])
                     2'd0: out_d = GPIO_WIDTH'((reg_v & ~bmask) | (wrep & bmask));
                     2'd1: dir_d = GPIO_WIDTH'((reg_v & ~bmask) | (wrep & bmask));
                     default: ;
                  endcase
               end else begin
                  dout_d = gpio_rd;
               end
            end else begin
               wait_d = 4'(RAM_WAIT);
               if (RAM_WAIT != 0) state_d = S_WAIT;
               else               state_d = we_q ? S_DONE : S_CAPTURE;
            end
         end
         S_WAIT: begin
            wait_d = wait_q - 4'd1;
            if (wait_q == 4'd1) state_d = we_q ? S_DONE : S_CAPTURE;
         end
         S_CAPTURE: begin
            dout_d  = ram_rd;
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wdat_q  <= '0;
         dout_q  <= '0;
         size_q  <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         gsel_q  <= 1'b0;
         wait_q  <= '0;
         out_q   <= '0;
         dir_q   <= '0;
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdat_q  <= wdat_d;
         dout_q  <= dout_d;
         size_q  <= size_d;
         we_q    <= we_d;
         err_q   <= err_d;
         gsel_q  <= gsel_d;
         wait_q  <= wait_d;
         out_q   <= out_d;
         dir_q   <= dir_d;
         sync1_q <= gpio;
         sync2_q <= sync1_q;
      end
   end

   assign busy      = state_q inside {S_ACCESS, S_WAIT, S_CAPTURE};
   assign done      = state_q == S_DONE;
   assign err       = done & err_q;
   assign ram_en    = (state_q == S_ACCESS) & ~gsel_q;
   assign ram_we    = (ram_en & we_q) ? lanes : 4'b0000;
   assign ram_addr  = addr_q[RAM_ADDR_WIDTH-1:2];
   assign ram_wdata = wrep;
   assign data_out  = dout_q;

   for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_pin
      assign gpio[i] = dir_q[i] ? out_q[i] : 1'bz;
   end

endmodule
